// File: rtl/datapath_wb.sv
// Two-stage register-file ALU: operand fetch into stage 1, then ALU, write-back, flags and result register.
// Latency 2 cycles, one op per cycle; hazards stall one cycle unless FORWARDING_EN bypasses the ALU result.
module datapath_wb #(
  parameter int WIDTH = 16,
  parameter int REGS  = 16,
  localparam int AW   = $clog2(REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [AW-1:0]    sel_a,
  input  logic [AW-1:0]    sel_b,
  input  logic [AW-1:0]    sel_d,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] imm,
  input  logic             flags_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [AW-1:0]    out_dst,
  output logic [3:0]       flags_zcso
);

  localparam int MSB = WIDTH - 1;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_NOT  = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_PASS = 5'd8;
  localparam logic [4:0] OP_ADDI = 5'd9;

  logic [WIDTH-1:0] rf_q [REGS];

  logic             s1_vld_q;
  logic [4:0]       s1_op_q;
  logic [AW-1:0]    s1_dst_q;
  logic             s1_we_q;
  logic [WIDTH-1:0] s1_imm_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [AW-1:0]    out_dst_q;
  logic [3:0]       flags_q;

  logic             s1_nop;
  logic             s1_writes;
  logic             haz_a;
  logic             haz_b;
  logic             accept;
  logic [WIDTH-1:0] opa_d;
  logic [WIDTH-1:0] opb_d;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_o;
  logic [3:0]       alu_flags;

  assign s1_nop    = (s1_op_q > OP_ADDI);
  assign s1_writes = s1_vld_q & s1_we_q & ~s1_nop;
  assign haz_a     = s1_writes & (s1_dst_q == sel_a);
  assign haz_b     = s1_writes & (s1_dst_q == sel_b);

`ifdef FORWARDING_EN
  assign in_ready = reset;
  assign opa_d    = haz_a ? alu_res : rf_q[sel_a];
  assign opb_d    = haz_b ? alu_res : rf_q[sel_b];
`else
  // Reads see the pre-write value, so a dependent op waits for the write-back edge.
  assign in_ready = reset & ~(haz_a | haz_b);
  assign opa_d    = rf_q[sel_a];
  assign opb_d    = rf_q[sel_b];
`endif

  assign accept = in_valid & in_ready;
  assign add_b  = (s1_op_q == OP_ADDI) ? s1_imm_q : s1_b_q;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    ext     = '0;
    case (s1_op_q)
      OP_ADD, OP_ADDI: begin
        ext     = {1'b0, s1_a_q} + {1'b0, add_b};
        alu_res = ext[MSB:0];
        alu_c   = ext[WIDTH];
        alu_o   = (s1_a_q[MSB] == add_b[MSB]) && (alu_res[MSB] != s1_a_q[MSB]);
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        ext     = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        alu_res = ext[MSB:0];
        alu_c   = ext[WIDTH];
        alu_o   = (s1_a_q[MSB] != s1_b_q[MSB]) && (alu_res[MSB] != s1_a_q[MSB]);
      end
      OP_AND:  alu_res = s1_a_q & s1_b_q;
      OP_OR:   alu_res = s1_a_q | s1_b_q;
      OP_XOR:  alu_res = s1_a_q ^ s1_b_q;
      OP_NOT:  alu_res = ~s1_a_q;
      OP_SHL: begin
        alu_res = {s1_a_q[MSB-1:0], 1'b0};
        alu_c   = s1_a_q[MSB];
      end
      OP_SHR: begin
        alu_res = {1'b0, s1_a_q[MSB:1]};
        alu_c   = s1_a_q[0];
      end
      OP_PASS: alu_res = s1_imm_q;
      default: alu_res = '0;
    endcase
    alu_flags = {(alu_res == '0), alu_c, alu_res[MSB], alu_o};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld_q <= 1'b0;
      s1_op_q  <= '0;
      s1_dst_q <= '0;
      s1_we_q  <= 1'b0;
      s1_imm_q <= '0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_op_q  <= op;
        s1_dst_q <= sel_d;
        s1_we_q  <= wr_en;
        s1_imm_q <= imm;
        s1_a_q   <= opa_d;
        s1_b_q   <= opb_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_dst_q   <= '0;
      flags_q     <= '0;
      for (int i = 0; i < REGS; i++) rf_q[i] <= '0;
    end else begin
      out_valid_q <= s1_vld_q;
      if (s1_vld_q) begin
        result_q  <= alu_res;
        out_dst_q <= s1_dst_q;
      end
      if (s1_writes) rf_q[s1_dst_q] <= alu_res;
      if (flags_clr) flags_q <= '0;
      else if (s1_vld_q && !s1_nop) flags_q <= alu_flags;
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign out_dst    = out_dst_q;
  assign flags_zcso = flags_q;

endmodule

// File: tb/tb_datapath_wb.sv
// Bench for datapath_wb: directed scenarios plus a random op stream checked against a sequential ISA model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_datapath_wb;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  dst;
    logic [3:0]  fl;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [3:0]  sel_a, sel_b, sel_d;
  logic        wr_en;
  logic [15:0] imm;
  logic        flags_clr;
  logic        out_valid;
  logic [15:0] result;
  logic [3:0]  out_dst;
  logic [3:0]  flags_zcso;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   m_rf [16];
  logic [3:0] m_fl;
  obs_t obs_q [$];
  obs_t exp_q [$];

  datapath_wb #(.WIDTH(16), .REGS(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .sel_a(sel_a), .sel_b(sel_b), .sel_d(sel_d), .wr_en(wr_en),
    .imm(imm), .flags_clr(flags_clr), .out_valid(out_valid), .result(result),
    .out_dst(out_dst), .flags_zcso(flags_zcso)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid === 1'b1) obs_q.push_back(obs_t'({result, out_dst, flags_zcso}));

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int sx(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  // Sequential ISA semantics: each op sees the architectural state left by the previous one.
  function automatic obs_t model(input int o, input int sa, input int sb, input int sd,
                                 input bit we, input int im);
    int a, b, r, sr;
    bit c, v;
    obs_t e;
    a = m_rf[sa]; b = m_rf[sb]; r = 0; sr = 0; c = 0; v = 0;
    if (o > 9) begin
      e.res = 16'h0; e.dst = sd[3:0]; e.fl = m_fl;
      return e;
    end
    case (o)
      0: begin r = a + b;  c = (r > 65535); sr = sx(a) + sx(b);  v = (sr > 32767) || (sr < -32768); end
      1: begin r = a - b;  c = (a < b);     sr = sx(a) - sx(b);  v = (sr > 32767) || (sr < -32768); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: begin r = a * 2; c = (a >= 32768); end
      7: begin r = a / 2; c = ((a % 2) == 1); end
      8: r = im;
      9: begin r = a + im; c = (r > 65535); sr = sx(a) + sx(im); v = (sr > 32767) || (sr < -32768); end
      default: r = 0;
    endcase
    r = r & 'hFFFF;
    m_fl = {(r == 0), c, (r >= 32768), v};
    if (we) m_rf[sd] = r;
    e.res = r[15:0]; e.dst = sd[3:0]; e.fl = m_fl;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = 0;
    m_fl = 4'b0000;
  endtask

  task automatic drive(input int o, input int sa, input int sb, input int sd, input bit we,
                       input int im, output int stalls);
    @(negedge clk);
    op = o[4:0]; sel_a = sa[3:0]; sel_b = sb[3:0]; sel_d = sd[3:0];
    wr_en = we; imm = im[15:0]; in_valid = 1'b1;
    #1;
    stalls = 0;
    while (!in_ready && stalls < 8) begin
      @(negedge clk); #1; stalls++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL accept_timeout: in_ready got %b want 1 after %0d cycles", in_ready, stalls);
    end
    @(posedge clk);
  endtask

  task automatic issue(input int o, input int sa, input int sb, input int sd, input bit we,
                       input int im, output int stalls);
    exp_q.push_back(model(o, sa, sb, sd, we, im));
    drive(o, sa, sb, sd, we, im, stalls);
  endtask

  task automatic idle_drain();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; op = 5'd8; imm = 16'hABCD; wr_en = 1'b1;
    sel_a = 0; sel_b = 0; sel_d = 1; flags_clr = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (result !== 16'h0) $display("FAIL rst_result: got %h want 0000", result); else n_pass++;
    n_chk++; if (out_dst !== 4'h0) $display("FAIL rst_out_dst: got %h want 0", out_dst); else n_pass++;
    n_chk++; if (flags_zcso !== 4'b0) $display("FAIL rst_flags: got %b want 0000", flags_zcso); else n_pass++;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready: got %b want 1", in_ready); else n_pass++;
    model_reset();
  endtask

  task automatic test_hazard();
    int st0, st1, want_st;
    obs_q.delete(); exp_q.delete();
    issue(8, 0, 0, 1, 1, 'h7FFF, st0);
    issue(9, 1, 1, 2, 1, 1, st1);
    idle_drain();
`ifdef FORWARDING_EN
    want_st = 0;
`else
    want_st = 1;
`endif
    n_chk++; if (st1 != want_st) $display("FAIL haz_stall: got %0d want %0d", st1, want_st); else n_pass++;
    n_chk++; if (obs_q.size() != 2) $display("FAIL haz_count: got %0d want 2", obs_q.size()); else n_pass++;
    if (obs_q.size() == 2) begin
      n_chk++; if (obs_q[0].res !== 16'h7FFF) $display("FAIL haz_pass: got %h want 7fff", obs_q[0].res); else n_pass++;
      n_chk++; if (obs_q[1] !== obs_t'({16'h8000, 4'd2, 4'b0011}))
        $display("FAIL haz_addi: got %h/%0d/%b want 8000/2/0011", obs_q[1].res, obs_q[1].dst, obs_q[1].fl);
      else n_pass++;
    end
  endtask

  task automatic test_add_sub();
    int st, lat;
    obs_q.delete(); exp_q.delete();
    issue(8, 0, 0, 1, 1, 'hFFFF, st);
    issue(8, 0, 0, 2, 1, 1, st);
    issue(0, 1, 2, 3, 1, 0, st);
    issue(1, 2, 1, 4, 1, 0, st);
    idle_drain();
    n_chk++; if (obs_q.size() != 4) $display("FAIL as_count: got %0d want 4", obs_q.size()); else n_pass++;
    if (obs_q.size() == 4) begin
      n_chk++; if (obs_q[2] !== obs_t'({16'h0000, 4'd3, 4'b1100}))
        $display("FAIL add_wrap: got %h/%0d/%b want 0000/3/1100", obs_q[2].res, obs_q[2].dst, obs_q[2].fl);
      else n_pass++;
      n_chk++; if (obs_q[3] !== obs_t'({16'h0002, 4'd4, 4'b0100}))
        $display("FAIL sub_borrow: got %h/%0d/%b want 0002/4/0100", obs_q[3].res, obs_q[3].dst, obs_q[3].fl);
      else n_pass++;
    end
    issue(9, 4, 4, 0, 0, 5, st);
    lat = 0;
    do begin
      @(negedge clk); in_valid = 1'b0; lat++;
    end while (out_valid !== 1'b1 && lat < 6);
    n_chk++; if (lat != 2) $display("FAIL latency: got %0d want 2", lat); else n_pass++;
    n_chk++; if (result !== 16'h0007) $display("FAIL addi_res: got %h want 0007", result); else n_pass++;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) $display("FAIL pulse_width: got %b want 0", out_valid); else n_pass++;
    n_chk++; if ({result, flags_zcso} !== {16'h0007, 4'b0000})
      $display("FAIL bubble_hold: got %h/%b want 0007/0000", result, flags_zcso);
    else n_pass++;
  endtask

  task automatic test_flags_clr();
    int st;
    obs_q.delete(); exp_q.delete();
    issue(0, 1, 1, 5, 1, 0, st);
    @(negedge clk); in_valid = 1'b0; flags_clr = 1'b1;
    @(negedge clk);
    n_chk++; if ({out_valid, result, flags_zcso} !== {1'b1, 16'hFFFE, 4'b0000})
      $display("FAIL clr_wins: got %b/%h/%b want 1/fffe/0000", out_valid, result, flags_zcso);
    else n_pass++;
    flags_clr = 1'b0;
    m_fl = 4'b0000;
    issue(9, 5, 5, 0, 0, 0, st);
    idle_drain();
    n_chk++; if (obs_q.size() == 0 || obs_q[$] !== obs_t'({16'hFFFE, 4'd0, 4'b0010}))
      $display("FAIL clr_writeback: got %h want fffe/0/0010", (obs_q.size() == 0) ? 24'h0 : obs_q[$]);
    else n_pass++;
    @(negedge clk); flags_clr = 1'b1;
    @(negedge clk); flags_clr = 1'b0;
    m_fl = 4'b0000;
    n_chk++; if (flags_zcso !== 4'b0000) $display("FAIL clr_alone: got %b want 0000", flags_zcso); else n_pass++;
  endtask

  task automatic test_nop();
    int st;
    obs_q.delete(); exp_q.delete();
    issue(9, 1, 1, 0, 0, 0, st);
    issue(31, 4, 4, 4, 1, 'h1234, st);
    issue(9, 4, 4, 0, 0, 0, st);
    idle_drain();
    n_chk++; if (obs_q.size() != 3) $display("FAIL nop_count: got %0d want 3", obs_q.size()); else n_pass++;
    if (obs_q.size() == 3) begin
      n_chk++; if (obs_q[1] !== obs_t'({16'h0000, 4'd4, 4'b0010}))
        $display("FAIL nop_out: got %h/%0d/%b want 0000/4/0010", obs_q[1].res, obs_q[1].dst, obs_q[1].fl);
      else n_pass++;
      n_chk++; if (obs_q[2].res !== 16'h0002) $display("FAIL nop_nowrite: got %h want 0002", obs_q[2].res); else n_pass++;
    end
  endtask

  task automatic test_reset_inflight();
    int st;
    obs_q.delete(); exp_q.delete();
    drive(8, 0, 0, 6, 1, 'h1111, st);
    drive(8, 0, 0, 7, 1, 'h2222, st);
    #1 reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_chk++; if ({out_valid, in_ready} !== 2'b00) $display("FAIL midrst_outs: got %b want 00", {out_valid, in_ready}); else n_pass++;
    @(negedge clk); reset = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    n_chk++; if (obs_q.size() != 0) $display("FAIL midrst_discard: got %0d outputs want 0", obs_q.size()); else n_pass++;
    issue(1, 1, 1, 5, 1, 0, st);
    issue(0, 6, 7, 8, 1, 0, st);
    idle_drain();
    n_chk++; if (obs_q.size() != 2) $display("FAIL postrst_count: got %0d want 2", obs_q.size()); else n_pass++;
    if (obs_q.size() == 2) begin
      n_chk++; if (obs_q[0] !== obs_t'({16'h0000, 4'd5, 4'b1000}))
        $display("FAIL postrst_sub: got %h/%0d/%b want 0000/5/1000", obs_q[0].res, obs_q[0].dst, obs_q[0].fl);
      else n_pass++;
      n_chk++; if (obs_q[1].res !== 16'h0000) $display("FAIL postrst_cleared: got %h want 0000", obs_q[1].res); else n_pass++;
    end
  endtask

  task automatic test_random();
    int o, sa, sb, sd, im, st, want_st, p_dst;
    bit we, p_wr, b2b;
    obs_q.delete(); exp_q.delete();
    b2b = 0; p_wr = 0; p_dst = 0;
    for (int n = 0; n < 316; n++) begin
      if (n < 300) begin
        o = $urandom_range(0, 11);
        if (o > 9) o = $urandom_range(10, 31);
        sa = $urandom_range(0, 15); sb = $urandom_range(0, 15); sd = $urandom_range(0, 15);
        we = ($urandom_range(0, 3) != 0); im = $urandom_range(0, 65535);
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clk); in_valid = 1'b0; b2b = 0;
        end
      end else begin
        o = 9; sa = n - 300; sb = sa; sd = 0; we = 0; im = 0;
      end
`ifdef FORWARDING_EN
      want_st = 0;
`else
      want_st = (b2b && p_wr && (p_dst == sa || p_dst == sb)) ? 1 : 0;
`endif
      issue(o, sa, sb, sd, we, im, st);
      n_chk++; if (st != want_st) $display("FAIL rnd_stall[%0d]: got %0d want %0d", n, st, want_st); else n_pass++;
      b2b = 1; p_wr = we && (o <= 9); p_dst = sd;
    end
    idle_drain();
    n_chk++; if (obs_q.size() != exp_q.size()) $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL rnd_out[%0d]: got %h/%0d/%b want %h/%0d/%b", i, obs_q[i].res, obs_q[i].dst,
                 obs_q[i].fl, exp_q[i].res, exp_q[i].dst, exp_q[i].fl);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_hazard();
    test_add_sub();
    test_flags_clr();
    test_nop();
    test_reset_inflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
